// File: rtl/perm_pkg.sv
// Shared constants and types for the Keccak permutation datapath.
// The state word is handled as NUM_CHUNKS indexed chunks of CHUNK_W bits.
package perm_pkg;

  localparam int CHUNK_W    = 200;
  localparam int NUM_CHUNKS = 8;
  localparam int IX_W       = $clog2(NUM_CHUNKS);
  localparam int STATE_W    = CHUNK_W * NUM_CHUNKS;

  typedef logic [CHUNK_W-1:0] chunk_t;
  typedef logic [STATE_W-1:0] state_t;
  typedef logic [IX_W-1:0]    ix_t;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_e;

  localparam ix_t LAST_IX = ix_t'(NUM_CHUNKS - 1);

endpackage

// File: rtl/perm_dout_ser_if.sv
// Bundle of upstream word handshake and downstream chunk stream for perm_dout_ser.
// The slave modport is the serializer's view; master is the surrounding logic.
interface perm_dout_ser_if import perm_pkg::*; ();

  logic   pushin;
  state_t sin;
  logic   busy;
  ix_t    doutix;
  chunk_t dout;
  logic   pushout;
  logic   stopin;
  logic   overrun;

  modport slave (
    input  pushin, sin, stopin,
    output busy, doutix, dout, pushout, overrun
  );

  modport master (
    output pushin, sin, stopin,
    input  busy, doutix, dout, pushout, overrun
  );

endinterface

// File: rtl/perm_chunk_sel.sv
// Combinational NUM_CHUNKS:1 mux picking chunk ix out of a held state word.
module perm_chunk_sel import perm_pkg::*; (
  input  state_t hold,
  input  ix_t    ix,
  output chunk_t chunk
);

  // Constant-base slices keep the select a plain mux rather than a shifter.
  always_comb begin
    chunk = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (ix == ix_t'(k)) chunk = hold[k*CHUNK_W +: CHUNK_W];
    end
  end

endmodule

// File: rtl/perm_dout_ser.sv
// Serializes one accepted 1600-bit state word into 8 indexed 200-bit chunks,
// with downstream stall, back-to-back acceptance on the last chunk and a sticky overrun flag.
module perm_dout_ser import perm_pkg::*; (
  input  logic            clk,
  input  logic            reset,
  perm_dout_ser_if.slave  bus
);

  ser_state_e state_q, state_d;
  ix_t        cnt_q, cnt_d;
  state_t     hold_q;
  logic       overrun_q;
  logic       load;
  logic       last;
  logic       xfer;
  logic       busy;
  logic       accept;

  assign last   = (cnt_q == LAST_IX);
  assign xfer   = (state_q == SEND) && !bus.stopin;
  // Ready again on the cycle the final chunk leaves, so words can chain without a gap.
  assign busy   = (state_q == SEND) && !(last && !bus.stopin);
  assign accept = bus.pushin && !busy;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (last) begin
            cnt_d = '0;
            if (accept) load    = 1'b1;
            else        state_d = IDLE;
          end else begin
            cnt_d = cnt_q + ix_t'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      // NOTE: the wide hold register is reset too, so dout reads zero after reset instead of a stale word.
      hold_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_q | (bus.pushin & busy);
      if (load) hold_q <= bus.sin;
    end
  end

  perm_chunk_sel u_sel (
    .hold  (hold_q),
    .ix    (cnt_q),
    .chunk (bus.dout)
  );

  assign bus.busy    = busy;
  assign bus.pushout = (state_q == SEND);
  assign bus.doutix  = cnt_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_perm_dout_ser.sv
// Self-checking bench for perm_dout_ser: table of stall patterns, back-to-back,
// overrun, mid-word reset and loopback, with a chunk scoreboard.
module tb_perm_dout_ser;
  import perm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  perm_dout_ser_if ifc ();

  perm_dout_ser dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  typedef struct {
    ix_t    ix;
    chunk_t data;
  } exp_t;

  typedef struct {
    logic [7:0] base;
    ix_t        stall_ix;
    int         stall_len;
    int         exp_lat;
  } vec_t;

  exp_t   sb[$];
  state_t loader;
  int     n_pass = 0;
  int     n_total = 0;

  task automatic check(input string name, input logic [CHUNK_W-1:0] act, input logic [CHUNK_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic state_t mk_word(input logic [7:0] base);
    state_t w;
    for (int k = 0; k < NUM_CHUNKS; k++)
      for (int b = 0; b < CHUNK_W / 8; b++)
        w[k*CHUNK_W + b*8 +: 8] = base + 8'(k);
    return w;
  endfunction

  task automatic push_exp(input state_t w);
    for (int k = 0; k < NUM_CHUNKS; k++) sb.push_back('{ix_t'(k), w[k*CHUNK_W +: CHUNK_W]});
  endtask

  // Scoreboard monitor: a chunk transfers when pushout && !stopin at the edge that follows.
  always @(negedge clk) begin
    if (!reset && ifc.pushout && !ifc.stopin) begin
      loader[ifc.doutix*CHUNK_W +: CHUNK_W] = ifc.dout;
      if (sb.size() == 0) begin
        check("unexpected_chunk", ifc.pushout, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("chunk_ix", ifc.doutix, e.ix);
        check("chunk_data", ifc.dout, e.data);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ifc.busy && n < 32) begin
      @(posedge clk); #1;
      n++;
    end
    if (ifc.busy) check("ready_timeout", ifc.busy, 1'b0);
  endtask

  // Offer one word, then drive stalls and check index/busy per cycle against a local model.
  task automatic run_word(input state_t w, input ix_t stall_ix, input int stall_len, output int lat);
    ix_t exp_ix = '0;
    int  left   = stall_len;
    bit  done   = 1'b0;
    wait_ready();
    ifc.pushin = 1'b1;
    ifc.sin    = w;
    push_exp(w);
    @(posedge clk); #1;
    ifc.pushin = 1'b0;
    lat = 1;
    while (!done && lat < 64) begin
      if (left > 0 && exp_ix == stall_ix) begin
        ifc.stopin = 1'b1;
        left--;
      end else begin
        ifc.stopin = 1'b0;
      end
      #1;
      check("pushout", ifc.pushout, 1'b1);
      check("doutix", ifc.doutix, exp_ix);
      check("busy", ifc.busy, !(exp_ix == LAST_IX && !ifc.stopin));
      if (!ifc.stopin) begin
        if (exp_ix == LAST_IX) done = 1'b1;
        else exp_ix++;
      end
      @(posedge clk); #1;
      if (!done) lat++;
    end
    ifc.stopin = 1'b0;
    if (!done) check("word_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    vec_t   vecs[5];
    int     lat;
    int     run;
    bit     sent;
    state_t a;
    state_t rw;

    vecs[0] = '{8'hA0, ix_t'(0), 0, 8};
    vecs[1] = '{8'hA0, ix_t'(3), 4, 12};
    vecs[2] = '{8'h10, ix_t'(0), 2, 10};
    vecs[3] = '{8'h40, ix_t'(7), 3, 11};
    vecs[4] = '{8'h5A, ix_t'(5), 1, 9};

    ifc.pushin = 1'b0;
    ifc.sin    = '0;
    ifc.stopin = 1'b0;
    loader     = '0;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_pushout", ifc.pushout, 1'b0);
    check("rst_doutix", ifc.doutix, 0);
    check("rst_dout", ifc.dout, 0);
    check("rst_busy", ifc.busy, 1'b0);
    check("rst_overrun", ifc.overrun, 1'b0);

    foreach (vecs[i]) begin
      run_word(mk_word(vecs[i].base), vecs[i].stall_ix, vecs[i].stall_len, lat);
      check("latency", lat, vecs[i].exp_lat);
      check("sb_drained", sb.size(), 0);
    end

    // Back-to-back: B offered while A's last chunk leaves.
    wait_ready();
    ifc.pushin = 1'b1;
    ifc.sin    = mk_word(8'h20);
    push_exp(mk_word(8'h20));
    @(posedge clk); #1;
    ifc.pushin = 1'b0;
    run  = 0;
    sent = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (!ifc.pushout) break;
      run++;
      if (ifc.doutix == LAST_IX && !sent) begin
        ifc.pushin = 1'b1;
        ifc.sin    = mk_word(8'h60);
        push_exp(mk_word(8'h60));
        sent = 1'b1;
      end else begin
        ifc.pushin = 1'b0;
      end
      @(posedge clk); #1;
    end
    ifc.pushin = 1'b0;
    check("b2b_run", run, 16);
    check("b2b_overrun", ifc.overrun, 1'b0);
    check("b2b_sb_drained", sb.size(), 0);

    // Overrun: push all-ones while chunk 2 is on the bus.
    wait_ready();
    a = mk_word(8'h80);
    ifc.pushin = 1'b1;
    ifc.sin    = a;
    push_exp(a);
    @(posedge clk); #1;
    ifc.pushin = 1'b0;
    sent = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (!ifc.pushout) break;
      if (sent && ifc.pushin) begin
        ifc.pushin = 1'b0;
        #1;
        check("overrun_set", ifc.overrun, 1'b1);
      end
      if (ifc.doutix == ix_t'(2) && !sent) begin
        check("ovr_busy", ifc.busy, 1'b1);
        ifc.pushin = 1'b1;
        ifc.sin    = '1;
        sent = 1'b1;
      end
      @(posedge clk); #1;
    end
    ifc.pushin = 1'b0;
    check("ovr_sb_drained", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("overrun_sticky", ifc.overrun, 1'b1);
    check("ovr_idle", ifc.pushout, 1'b0);

    // Mid-word reset at chunk 5.
    wait_ready();
    ifc.pushin = 1'b1;
    ifc.sin    = mk_word(8'hC0);
    push_exp(mk_word(8'hC0));
    @(posedge clk); #1;
    ifc.pushin = 1'b0;
    for (int c = 0; c < 16 && ifc.doutix != ix_t'(5); c++) begin
      @(posedge clk); #1;
    end
    check("pre_reset_ix", ifc.doutix, 5);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_pushout", ifc.pushout, 1'b0);
    check("mid_rst_doutix", ifc.doutix, 0);
    check("mid_rst_dout", ifc.dout, 0);
    check("mid_rst_busy", ifc.busy, 1'b0);
    check("mid_rst_overrun", ifc.overrun, 1'b0);
    @(posedge clk); #1;
    check("post_rst_quiet", ifc.pushout, 1'b0);
    run_word(mk_word(8'hE0), ix_t'(0), 0, lat);
    check("restart_latency", lat, 8);

    // Loopback into a chunk loader model.
    for (int i = 0; i < STATE_W / 32; i++) rw[i*32 +: 32] = $urandom;
    loader = '0;
    run_word(rw, ix_t'(0), 0, lat);
    for (int k = 0; k < NUM_CHUNKS; k++)
      check("loopback", loader[k*CHUNK_W +: CHUNK_W], rw[k*CHUNK_W +: CHUNK_W]);
    check("final_sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
